// File: rtl/ha_serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell (two half adders + OR) reused over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.

module ha_half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module ha_serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_q;
  logic [CNT_W-1:0]   cnt;
  logic               carry_q;
  logic               carry_out_q;
  logic               busy_q;
  logic               done_q;
  logic               last_bit;

  logic               ha0_s;
  logic               ha0_c;
  logic               cell_sum;
  logic               ha1_c;
  logic               cell_carry;

  // Shared full-adder cell built from two half adders.
  ha_half_adder u_ha0 (
    .x (a_sh[0]),
    .y (b_sh[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  ha_half_adder u_ha1 (
    .x (ha0_s),
    .y (carry_q),
    .s (cell_sum),
    .c (ha1_c)
  );

  assign cell_carry = ha0_c | ha1_c;
  assign last_bit   = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_SHIFT;
      S_SHIFT: if (last_bit) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      ovf_q <= 1'b0;
    end else if (state == S_SHIFT && last_bit) begin
      // Carry into the MSB differs from carry out of it => signed overflow.
      ovf_q <= carry_q ^ cell_carry;
    end
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_q       <= '0;
      cnt         <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next == S_SHIFT);
      done_q <= (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh        <= a;
            b_sh        <= b;
            sum_q       <= '0;
            cnt         <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
          end
        end
        S_SHIFT: begin
          sum_q   <= {cell_sum, sum_q[WIDTH-1:1]};
          carry_q <= cell_carry;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          cnt     <= last_bit ? '0 : cnt + CNT_W'(1);
          // Load carry_out on the final step so it is valid together with done.
          if (last_bit) carry_out_q <= cell_carry;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_ha_serial_adder_ctrl.sv
// Directed and random checks of ha_serial_adder_ctrl at WIDTH=8.
// Checks ovf as well when built with SERIAL_ADD_OVF_EN.

module tb_ha_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         ovf_cap;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  ha_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic capture_ovf();
`ifdef SERIAL_ADD_OVF_EN
    ovf_cap = ovf;
`else
    ovf_cap = 1'b0;
`endif
  endtask

  // One operation from IDLE; returns result plus observed latency and busy length.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       output logic [W-1:0] rs, output logic rc,
                       output int lat, output int busy_cnt, output int overlap);
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    lat = 1; busy_cnt = 0; overlap = 0;
    while (!done && lat < 30) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy && done) overlap++;
    rs = sum; rc = carry_out;
    capture_ovf();
    @(posedge clk); #1;
    if (done) overlap++;
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    logic [W:0]   ref_sum;
    logic [W-1:0] ra, rb;
    int lat, busy_cnt, overlap, done_cnt, done_at0, done_at1;
    logic [W-1:0] s0, s1;
    logic         c0, c1;

    vecs[0] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1, v: 1'b0};
    vecs[1] = '{a: 8'h3C, b: 8'h55, s: 8'h91, c: 1'b0, v: 1'b1};
    vecs[2] = '{a: 8'h7F, b: 8'h01, s: 8'h80, c: 1'b0, v: 1'b1};
    vecs[3] = '{a: 8'h0A, b: 8'h05, s: 8'h0F, c: 1'b0, v: 1'b0};
    vecs[4] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0, v: 1'b0};
    vecs[5] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1, v: 1'b1};
    vecs[6] = '{a: 8'hAA, b: 8'h55, s: 8'hFF, c: 1'b0, v: 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_carry", carry_out, 0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, rs, rc, lat, busy_cnt, overlap);
      chk($sformatf("vec%0d_sum", i), rs, vecs[i].s);
      chk($sformatf("vec%0d_carry", i), rc, vecs[i].c);
      chk($sformatf("vec%0d_latency", i), lat, W + 1);
      chk($sformatf("vec%0d_busy_len", i), busy_cnt, W);
      chk($sformatf("vec%0d_overlap", i), overlap, 0);
`ifdef SERIAL_ADD_OVF_EN
      chk($sformatf("vec%0d_ovf", i), ovf_cap, vecs[i].v);
`endif
      chk($sformatf("vec%0d_sum_held", i), sum, vecs[i].s);
    end

    // Start pulses during SHIFT (i=3) and during DONE (i=9) must be ignored.
    @(negedge clk);
    a = 8'h3C; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0; busy_cnt = 1; s0 = '0; c0 = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 3 || i == 9) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; s0 = sum; c0 = carry_out; end
    end
    chk("ignore_done_count", done_cnt, 1);
    chk("ignore_busy_len", busy_cnt, W);
    chk("ignore_sum", s0, 8'h91);
    chk("ignore_carry", c0, 0);
    chk("ignore_sum_held", sum, 8'h91);

    // Reset sampled at the 4th SHIFT edge aborts the operation.
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_carry", carry_out, 0);
    @(negedge clk); rst = 1'b0;
    done_cnt = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done || busy) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    do_op(8'h0A, 8'h05, rs, rc, lat, busy_cnt, overlap);
    chk("after_abort_sum", rs, 8'h0F);
    chk("after_abort_carry", rc, 0);

    // rst and start together: reset wins.
    @(negedge clk); rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_busy", busy, 0);

    // Start held continuously: new operation accepted every W+2 cycles.
    @(negedge clk);
    a = 8'h00; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h80; b = 8'h80;
    done_at0 = -1; done_at1 = -1; s0 = '1; s1 = '1; c0 = 1'b1; c1 = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk); #1;
      if (done && done_at0 < 0) begin done_at0 = c; s0 = sum; c0 = carry_out; end
      else if (done) begin done_at1 = c; s1 = sum; c1 = carry_out; end
      if (c == 18) start = 1'b0;
    end
    chk("b2b_first_done", done_at0, W);
    chk("b2b_second_done", done_at1, 2 * W + 2);
    chk("b2b_first_sum", s0, 8'h00);
    chk("b2b_first_carry", c0, 0);
    chk("b2b_second_sum", s1, 8'h00);
    chk("b2b_second_carry", c1, 1);
    repeat (12) @(posedge clk);
    #1;
    chk("b2b_idle", busy, 0);

    // Random operands against the bench's own a+b.
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom); rb = W'($urandom);
      ref_sum = {1'b0, ra} + {1'b0, rb};
      do_op(ra, rb, rs, rc, lat, busy_cnt, overlap);
      if ({rc, rs} !== ref_sum || lat != W + 1 || overlap != 0) begin
        chk($sformatf("rand%0d_result", n), {rc, rs}, ref_sum);
        chk($sformatf("rand%0d_latency", n), lat, W + 1);
        chk($sformatf("rand%0d_overlap", n), overlap, 0);
      end else begin
        total++;
      end
`ifdef SERIAL_ADD_OVF_EN
      chk($sformatf("rand%0d_ovf", n), ovf_cap, (ra[W-1] == rb[W-1]) && (rs[W-1] != ra[W-1]));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
